// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: MEM-stage load/store request bus between the pipeline
// (master) and the memory controller (slave).
//   read_i       load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   write_i      store type: 0 none, 1 SB, 2 SH, 3 SW
//   addr_i       byte address of the request
//   wdata_i      store data, low 1/2/4 bytes used
//   read_busy_o  load in progress
//   write_busy_o store in progress
//   finish_o     one-cycle completion pulse
//   read_data_o  extended load result, valid with finish_o after a load
interface mem_ctrl_if;
  logic [2:0]  read_i;
  logic [1:0]  write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        read_busy_o;
  logic        write_busy_o;
  logic        finish_o;
  logic [31:0] read_data_o;

  modport master (
    output read_i, write_i, addr_i, wdata_i,
    input  read_busy_o, write_busy_o, finish_o, read_data_o
  );

  modport slave (
    input  read_i, write_i, addr_i, wdata_i,
    output read_busy_o, write_busy_o, finish_o, read_data_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for MEM-stage loads/stores over a byte-wide
// synchronous RAM, one byte per cycle, little-endian.
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   bus          mem_ctrl_if.slave request/response bus
//   ram_a_o      RAM byte address (low RAM_AW bits of the byte address)
//   ram_dout_o   RAM write byte
//   ram_wr_o     RAM write enable
//   ram_din_i    RAM read byte, valid one cycle after ram_a_o
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_LAST = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Sign/zero extension of the assembled load word by load type.
  function automatic logic [31:0] extend_load(input logic [2:0] kind, input logic [31:0] w);
    logic [31:0] r;
    case (kind)
      3'd1:    r = {{24{w[7]}}, w[7:0]};
      3'd2:    r = {{16{w[15]}}, w[15:0]};
      3'd4:    r = {24'd0, w[7:0]};
      3'd5:    r = {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        kind_q, kind_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;       // bytes in this transfer
  logic [2:0]        idx_q, idx_d;   // next byte offset to address
  logic [1:0]        cap_q, cap_d;   // next byte slot to capture
  logic [31:0]       data_q, data_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              read_busy_q, read_busy_d;
  logic              write_busy_q, write_busy_d;
  logic              finish_q, finish_d;
  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic              wr_req_s;
  logic              rd_req_s;
  logic [31:0]       word_s;
  logic [RAM_AW-1:0] next_a_s;

  assign wr_req_s = (bus.write_i != 2'd0);
  assign rd_req_s = (bus.read_i >= 3'd1) && (bus.read_i <= 3'd5);
  // Truncating before the add gives the same low bits as a 32-bit add.
  assign next_a_s = addr_q + RAM_AW'(idx_q);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kind_q       <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      n_q          <= 3'd0;
      idx_q        <= 3'd0;
      cap_q        <= 2'd0;
      data_q       <= 32'd0;
      read_data_q  <= 32'd0;
      read_busy_q  <= 1'b0;
      write_busy_q <= 1'b0;
      finish_q     <= 1'b0;
      ram_a_q      <= '0;
      ram_dout_q   <= 8'd0;
      ram_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      data_q       <= data_d;
      read_data_q  <= read_data_d;
      read_busy_q  <= read_busy_d;
      write_busy_q <= write_busy_d;
      finish_q     <= finish_d;
      ram_a_q      <= ram_a_d;
      ram_dout_q   <= ram_dout_d;
      ram_wr_q     <= ram_wr_d;
    end
  end

  // Next-state and output logic for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    n_d          = n_q;
    idx_d        = idx_q;
    cap_d        = cap_q;
    data_d       = data_q;
    read_data_d  = read_data_q;
    read_busy_d  = read_busy_q;
    write_busy_d = write_busy_q;
    finish_d     = 1'b0;
    ram_a_d      = ram_a_q;
    ram_dout_d   = ram_dout_q;
    ram_wr_d     = ram_wr_q;
    // Captured bytes merged with the byte arriving this cycle.
    word_s = data_q;
    word_s[{cap_q, 3'b000} +: 8] = ram_din_i;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (wr_req_s || rd_req_s) begin
          addr_d  = bus.addr_i[RAM_AW-1:0];
          wdata_d = bus.wdata_i;
          ram_a_d = bus.addr_i[RAM_AW-1:0];
          idx_d   = 3'd1;
          cap_d   = 2'd0;
          data_d  = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
        // A store wins over a simultaneous load.
        if (wr_req_s) begin
          state_d      = S_WR;
          kind_d       = 3'd0;
          write_busy_d = 1'b1;
          ram_wr_d     = 1'b1;
          ram_dout_d   = bus.wdata_i[7:0];
          case (bus.write_i)
            2'd1:    n_d = 3'd1;
            2'd2:    n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
        end else if (rd_req_s) begin
          state_d     = S_RD;
          kind_d      = bus.read_i;
          read_busy_d = 1'b1;
          case (bus.read_i)
            3'd1, 3'd4: n_d = 3'd1;
            3'd2, 3'd5: n_d = 3'd2;
            default:    n_d = 3'd4;
          endcase
        end else begin
          kind_d = kind_q;
        end
      end
      S_RD: begin
        // The first RD cycle has no data back yet.
        if (idx_q != 3'd1) begin
          data_d = word_s;
          cap_d  = cap_q + 2'd1;
        end else begin
          cap_d = cap_q;
        end
        if (idx_q == n_q) begin
          state_d = S_RD_LAST;
        end else begin
          ram_a_d = next_a_s;
          idx_d   = idx_q + 3'd1;
        end
      end
      S_RD_LAST: begin
        read_data_d = extend_load(kind_q, word_s);
        read_busy_d = 1'b0;
        finish_d    = 1'b1;
        state_d     = S_DONE;
      end
      S_WR: begin
        if (idx_q == n_q) begin
          ram_wr_d     = 1'b0;
          write_busy_d = 1'b0;
          finish_d     = 1'b1;
          state_d      = S_DONE;
        end else begin
          ram_a_d    = next_a_s;
          ram_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
          idx_d      = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.read_busy_o  = read_busy_q;
  assign bus.write_busy_o = write_busy_q;
  assign bus.finish_o     = finish_q;
  assign bus.read_data_o  = read_data_q;
  assign ram_a_o          = ram_a_q;
  assign ram_dout_o       = ram_dout_q;
  assign ram_wr_o         = ram_wr_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the MEM-stage load/store request interface.
- Accepts one read or write request at a time from the MEM stage and performs it over a byte-wide synchronous RAM port, one byte per cycle, little-endian.
- For loads, assembles the bytes into a word with sign or zero extension, then returns it with a one-cycle finish pulse.
- Holds busy high for the whole transfer so the MEM stage stalls.

Parameters:
- RAM_AW, 17, RAM byte-address width; ram_a_o = low RAM_AW bits of the 32-bit byte address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- read_i  in  3  load request type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 reserved.
- write_i  in  2  store request type: 0 none, 1 SB, 2 SH, 3 SW.
- addr_i  in  32  byte address of the request.
- wdata_i  in  32  store data; the low 1/2/4 bytes are used.
- read_busy_o  out  1  a read is in progress.
- write_busy_o  out  1  a write is in progress.
- finish_o  out  1  one-cycle completion pulse.
- read_data_o  out  32  extended load result; valid when finish_o=1 after a read.
- ram_a_o  out  RAM_AW  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_wr_o  out  1  RAM write enable.
- ram_din_i  in  8  RAM read byte; valid one cycle after ram_a_o is presented.

Behaviour:
- Reset values, all applied at the first edge with rst=1:
  - read_busy_o, write_busy_o, finish_o, ram_wr_o = 0.
  - read_data_o, ram_a_o, ram_dout_o = 0.
  - State IDLE; internal counters and shift registers cleared.
- Reset mid-transfer aborts the transfer at that edge: no finish pulse is produced, and no further RAM writes occur after that edge.
- States: IDLE, RD, RD_LAST, WR, DONE.
- IDLE accepts a request at an edge where busy=0 and (write_i≠0 or read_i∈1..5):
  - Latch type, addr_i and wdata_i.
  - Set the matching busy output.
  - Set byte count n = 1 (B), 2 (H) or 4 (W).
- Simultaneous read_i≠0 and write_i≠0: the write is accepted and the read is ignored.
- Reserved read_i codes 6 and 7 are ignored; the block stays in IDLE.
- Requests presented while busy=1 are ignored. The MEM stage must hold its request until it sees finish_o.
- Cycle numbering: cycle k is the k-th clock period after the accept edge.
- Read sequence:
  - RD drives ram_a_o = addr+i in cycle i+1, for i = 0..n-1.
  - Byte i is captured from ram_din_i at the end of cycle i+2.
  - RD_LAST absorbs the final RAM latency cycle.
  - DONE is cycle n+2: finish_o=1, read_data_o holds the assembled value, read_busy_o=0.
  - Load latency from the accept edge: LB/LBU 3 cycles, LH/LHU 4, LW 6.
- Write sequence:
  - WR drives ram_wr_o=1, ram_a_o = addr+i, ram_dout_o = wdata byte i in cycle i+1, for i = 0..n-1.
  - DONE is cycle n+1: finish_o=1, write_busy_o=0, ram_wr_o=0.
  - read_data_o is unchanged by writes.
- Busy deasserts in the same cycle that finish_o asserts.
- A new request may be accepted at the edge ending the DONE cycle, so back-to-back requests have no bubble beyond DONE.
- Extension rules:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW takes the byte order {b3,b2,b1,b0}.
- Address arithmetic:
  - addr+i is computed modulo 2^32, then truncated to RAM_AW bits.
  - Crossing the top of RAM wraps to address 0.
  - No alignment check; unaligned halfwords and words are legal.
- ram_wr_o is never 1 outside WR. ram_a_o holds its last value when idle.

Test Plan:
- LW at 0x100; RAM[0x100..0x103] = 11,22,33,44 → finish_o in cycle 6, read_data_o=0x44332211, read_busy_o high in cycles 1–5.
- LB, then LBU, at 0x20 with RAM=0x80 → LB gives 0xFFFFFF80 and LBU gives 0x00000080, each finishing in cycle 3. LH at 0x21 with bytes FE,FF gives 0xFFFFFFFE.
- SW 0xDEADBEEF at 0x40 → ram_wr_o high in cycles 1–4 with a/data (40,EF),(41,BE),(42,AD),(43,DE), finish in cycle 5. A following LW at 0x40 returns 0xDEADBEEF.
- SH at 0x1FFFF, RAM_AW=17, wdata 0x1234 → writes 0x34 to 0x1FFFF and 0x12 to 0x00000 (wrap).
- read_i=3 and write_i=3 asserted together → write performed, no RAM read issued. read_i=7 → ignored, busy stays 0.
- rst asserted in cycle 2 of an SW → ram_wr_o=0 and busy=0 from the next cycle, no finish pulse, RAM bytes 2–3 unwritten.
